// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the cpu main-memory path: arbiter FSM states,
// grant encoding and the default memory latency.
package cpu_mem_pkg;

    localparam int MEM_LATENCY = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
    typedef enum logic [1:0] {G_NONE, G_IF, G_D} grant_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Memory latency down-counter: loaded when an access is issued, decremented while
// waiting, and flags the last wait cycle (count of one).
module mem_lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == W'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-ported fixed-latency main memory between the fetch (IF) and
// data (D) ports of the cpu, sequencing each access as issue -> wait -> respond.
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int LATENCY = MEM_LATENCY,
    parameter int AW      = 16,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_ready,
    output logic          busy
);

    arb_state_t state;
    grant_t     grant;
    logic       req_wr;
    logic       lat_tc;
    logic       take_d;
    logic       take_if;
    logic       resp_next;

    // The port just served in RESP is excluded, so contention alternates.
    assign take_d    = d_req && ((state == IDLE) || ((state == RESP) && (grant == G_IF)));
    assign take_if   = !take_d && if_req &&
                       ((state == IDLE) || ((state == RESP) && (grant == G_D)));
    assign resp_next = ((state == ISSUE) && (LATENCY == 1)) || ((state == WAIT) && lat_tc);

    mem_lat_counter #(.W(4)) u_lat_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == ISSUE),
        .load_val (4'(LATENCY - 1)),
        .dec      (state == WAIT),
        .tc       (lat_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= G_NONE;
            req_wr    <= 1'b0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_wr <= 1'b0;
            if_ack <= resp_next && (grant == G_IF);
            d_ack  <= resp_next && (grant == G_D);
            if (take_d) begin
                state     <= ISSUE;
                grant     <= G_D;
                req_wr    <= d_wr;
                mem_en    <= 1'b1;
                mem_wr    <= d_wr;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (take_if) begin
                state    <= ISSUE;
                grant    <= G_IF;
                req_wr   <= 1'b0;
                mem_en   <= 1'b1;
                mem_addr <= if_addr;
            end else begin
                case (state)
                    ISSUE:   state <= (LATENCY == 1) ? RESP : WAIT;
                    WAIT:    if (lat_tc) state <= RESP;
                    RESP: begin
                        state <= IDLE;
                        grant <= G_NONE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Read data is only valid in the ack cycle, so it is passed straight through.
    assign if_rdata  = if_ack ? mem_rdata : '0;
    assign d_rdata   = (d_ack && !req_wr) ? mem_rdata : '0;
    assign mem_ready = !((if_req && !if_ack) || (d_req && !d_ack));
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter at LATENCY 4 and 1, checked against a cycle-count
// transaction model and a behavioural fixed-latency memory.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    int   mode;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    task automatic chk_val(input int lat, input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL L%0d %s: got 0x%0h expected 0x%0h at %0t", lat, tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] init_w(input int a);
        return 16'(a * 40503 + 7);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : 1;

        logic        if_req, d_req, d_wr, if_ack, d_ack, mem_en, mem_wr, mem_ready, busy;
        logic [15:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
        logic [15:0] mem_addr, mem_wdata, mem_rdata;

        mem_arbiter #(.LATENCY(L), .AW(16), .DW(16)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_ack    (if_ack),
            .if_rdata  (if_rdata),
            .d_req     (d_req),
            .d_wr      (d_wr),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_ack     (d_ack),
            .d_rdata   (d_rdata),
            .mem_en    (mem_en),
            .mem_wr    (mem_wr),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata),
            .mem_ready (mem_ready),
            .busy      (busy)
        );

        initial begin : run
            logic [15:0] dev [int];
            logic [15:0] shd [int];
            logic [15:0] due [int];
            int          c, st;
            bit          act, prt_d, m_wr, post_rst, armed, fin, take_d, take_if;
            bit          e_en, e_ifack, e_dack, e_busy, e_ready;
            logic [15:0] m_addr, m_wdata, e_data;

            c = 0; st = 0; act = 0; prt_d = 0; m_wr = 0; armed = 0;
            m_addr = '0; m_wdata = '0; e_data = '0;
            if_req = 0; d_req = 0; d_wr = 0;
            if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
            forever begin
                @(posedge clk);
                #1;
                c++;
                post_rst = !rst_n;
                if (post_rst) begin
                    act   = 0;
                    armed = 1;
                end
                mem_rdata = due.exists(c) ? due[c] : 16'($urandom);
                @(negedge clk);
                if (armed) begin
                    e_en    = act && (c == st);
                    fin     = act && (c == st + L);
                    e_ifack = fin && !prt_d;
                    e_dack  = fin && prt_d;
                    e_busy  = act && (c >= st);
                    e_ready = !((if_req && !e_ifack) || (d_req && !e_dack));
                    if (e_en && !m_wr)
                        e_data = shd.exists(int'(m_addr)) ? shd[int'(m_addr)] : init_w(int'(m_addr));
                    if (e_en && m_wr)
                        shd[int'(m_addr)] = m_wdata;

                    chk_val(L, "mem_en", 32'(mem_en), 32'(e_en));
                    chk_val(L, "if_ack", 32'(if_ack), 32'(e_ifack));
                    chk_val(L, "d_ack", 32'(d_ack), 32'(e_dack));
                    chk_val(L, "busy", 32'(busy), 32'(e_busy));
                    chk_val(L, "mem_ready", 32'(mem_ready), 32'(e_ready));
                    chk_val(L, "if_rdata", 32'(if_rdata), 32'(e_ifack ? e_data : 16'h0));
                    chk_val(L, "d_rdata", 32'(d_rdata), 32'((e_dack && !m_wr) ? e_data : 16'h0));
                    if (e_en) begin
                        chk_val(L, "mem_addr", 32'(mem_addr), 32'(m_addr));
                        chk_val(L, "mem_wr", 32'(mem_wr), 32'(m_wr));
                        if (m_wr) chk_val(L, "mem_wdata", 32'(mem_wdata), 32'(m_wdata));
                    end
                    if (post_rst) begin
                        chk_val(L, "rst_mem_addr", 32'(mem_addr), 32'h0);
                        chk_val(L, "rst_mem_wdata", 32'(mem_wdata), 32'h0);
                    end

                    // Behavioural memory reacting to the strobe it actually sees.
                    if (mem_en) begin
                        if (mem_wr) dev[int'(mem_addr)] = mem_wdata;
                        else due[c + L] = dev.exists(int'(mem_addr)) ? dev[int'(mem_addr)]
                                                                     : init_w(int'(mem_addr));
                    end

                    // Requesters: re-request after an ack, occasionally drop or disturb.
                    if (e_ifack || !if_req) begin
                        if ((mode != 0) || ($urandom_range(0, 9) < 3)) begin
                            if_req  = 1;
                            if_addr = 16'($urandom_range(0, 15));
                        end else begin
                            if_req = 0;
                        end
                    end else if (mode == 0) begin
                        case ($urandom_range(0, 19))
                            0:       if_req = 0;
                            1, 2:    if_addr = 16'($urandom_range(0, 15));
                            default: ;
                        endcase
                    end
                    if (e_dack || !d_req) begin
                        if ((mode == 1) || ((mode == 0) && ($urandom_range(0, 9) < 3))) begin
                            d_req   = 1;
                            d_wr    = ($urandom_range(0, 2) == 0);
                            d_addr  = 16'($urandom_range(0, 15));
                            d_wdata = 16'($urandom);
                        end else begin
                            d_req = 0;
                        end
                    end else if (mode == 0) begin
                        case ($urandom_range(0, 19))
                            0:       d_req = 0;
                            1, 2: begin
                                d_wr    = ($urandom_range(0, 1) == 0);
                                d_addr  = 16'($urandom_range(0, 15));
                                d_wdata = 16'($urandom);
                            end
                            default: ;
                        endcase
                    end

                    // Next transaction: D wins from idle, the just-served port sits out.
                    if (!act || fin) begin
                        take_d  = d_req && !(fin && prt_d);
                        take_if = !take_d && if_req && !(fin && !prt_d);
                        act     = take_d || take_if;
                        if (act) begin
                            st      = c + 1;
                            prt_d   = take_d;
                            m_wr    = take_d && d_wr;
                            m_addr  = take_d ? d_addr : if_addr;
                            m_wdata = d_wdata;
                        end
                    end
                end
            end
        end
    end

    initial begin
        mode  = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        for (int ph = 0; ph < 4; ph++) begin
            mode = (ph == 1) ? 1 : ((ph == 2) ? 2 : 0);
            for (int i = 0; i < 500; i++) begin
                @(posedge clk);
                #2;
                if ((mode == 0) && rst_n && ($urandom_range(0, 99) == 0)) rst_n = 1'b0;
                else rst_n = 1'b1;
            end
        end
        @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
